// File: rtl/sched_pkg.sv
// Shared types and helpers for the nonce sweep scheduler and its stream stages.
package sched_pkg;

    typedef logic [31:0] nonce_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, REPORT} sched_state_t;

    function automatic int unsigned rounds(input int unsigned bcast, input int unsigned cores);
        return (bcast + cores - 1) / cores;
    endfunction

endpackage

// File: rtl/inflight_tracker.sv
// Counts issued-but-unanswered transactions; a decrement while empty is flagged and dropped.
module inflight_tracker #(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          underflow_err
);

    logic [CW-1:0] count_q, count_d;
    logic          dec_ok;

    always_comb begin
        dec_ok  = dec && (count_q != '0);
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec_ok) begin
            count_d = count_q + 1'b1;
        end else if (!inc && dec_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count         = count_q;
    assign full          = (count_q == CW'(MAX_INFLIGHT));
    assign empty         = (count_q == '0);
    assign underflow_err = dec && empty;

endmodule

// File: rtl/nonce_sweep_scheduler.sv
// Schedules one block header as ROUNDS back-pressurable nonce-base broadcasts and resolves the
// first winning nonce. Define SCHED_EARLY_EXIT_EN to stop issuing once a hit is found.
module nonce_sweep_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned NUM_CORES     = 10,
    parameter int unsigned BROADCAST_CNT = 100,
    parameter int unsigned MAX_INFLIGHT  = 4,
    parameter int unsigned PARTITIONBITS = $clog2(NUM_CORES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     block_valid_i,
    output logic                     block_ready_o,
    output logic                     newblock_o,
    output logic                     issue_valid_o,
    input  logic                     issue_ready_i,
    output logic [31:0]              issue_base_o,
    input  logic                     result_valid_i,
    input  logic                     result_success_i,
    input  logic [PARTITIONBITS-1:0] result_prefix_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_success_o,
    output logic [31:0]              out_nonce_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int unsigned ROUNDS = rounds(BROADCAST_CNT, NUM_CORES);
    localparam int unsigned CW     = $clog2(MAX_INFLIGHT + 1);

    sched_state_t  state_q, state_d;
    nonce_t        issue_base_q, result_base_q, issued_rounds_q, nonce_q, cand;
    logic          found_q, err_q;
    logic [CW-1:0] inflight;
    logic          full, empty, underflow_err;
    logic          accept, issue_valid, issue_hs, res_in_sweep, res_ok, prefix_bad, hit_ok;
    logic          err_set, stop_issue;

`ifdef SCHED_EARLY_EXIT_EN
    assign stop_issue = found_q;
`else
    assign stop_issue = 1'b0;
`endif

    always_comb begin
        accept       = (state_q == IDLE) && block_valid_i;
        issue_valid  = (state_q == ISSUE) && !full && !stop_issue;
        issue_hs     = issue_valid && issue_ready_i;
        res_in_sweep = result_valid_i && ((state_q == ISSUE) || (state_q == DRAIN));
        res_ok       = res_in_sweep && !empty;
        prefix_bad   = result_success_i && (32'(result_prefix_i) >= NUM_CORES);
        cand         = result_base_q + nonce_t'(result_prefix_i);
        // Only the first in-range hit is kept; later successes are ignored.
        hit_ok       = res_ok && result_success_i && !prefix_bad && !found_q
                       && (cand < BROADCAST_CNT);
        err_set      = (result_valid_i && !res_in_sweep) || underflow_err
                       || (result_valid_i && prefix_bad);
    end

    inflight_tracker #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_inflight (
        .clk           (clk),
        .rst           (rst),
        .inc           (issue_hs),
        .dec           (res_in_sweep),
        .clr           (accept),
        .count         (inflight),
        .full          (full),
        .empty         (empty),
        .underflow_err (underflow_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (block_valid_i) state_d = ISSUE;
            ISSUE: begin
                if (issue_hs && (issued_rounds_q == nonce_t'(ROUNDS - 1))) begin
                    state_d = DRAIN;
                end else if (stop_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   if ((inflight == '0) && !result_valid_i) state_d = REPORT;
            REPORT:  if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        block_ready_o = (state_q == IDLE);
        issue_valid_o = issue_valid;
        newblock_o    = issue_valid && (issue_base_q == '0);
        issue_base_o  = issue_valid ? issue_base_q : '0;
        out_valid_o   = (state_q == REPORT);
        out_success_o = (state_q == REPORT) && found_q;
        out_nonce_o   = (state_q == REPORT) ? nonce_q : '0;
        busy_o        = (state_q != IDLE);
        err_o         = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_base_q    <= '0;
            result_base_q   <= '0;
            issued_rounds_q <= '0;
            found_q         <= 1'b0;
            nonce_q         <= '0;
            err_q           <= 1'b0;
        end else begin
            if (accept) begin
                issue_base_q    <= '0;
                result_base_q   <= '0;
                issued_rounds_q <= '0;
                found_q         <= 1'b0;
                nonce_q         <= '0;
            end else begin
                if (issue_hs) begin
                    issue_base_q    <= issue_base_q + NUM_CORES;
                    issued_rounds_q <= issued_rounds_q + 32'd1;
                end
                if (res_ok) begin
                    result_base_q <= result_base_q + NUM_CORES;
                end
                if (hit_ok) begin
                    found_q <= 1'b1;
                    nonce_q <= cand;
                end
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Directed bench for nonce_sweep_scheduler with a fixed-latency core-array model.
// BROADCAST_CNT=95 so the last round (base 90) is partial; ROUNDS is still 10.
module tb_nonce_sweep_scheduler;
    import sched_pkg::*;

    localparam int unsigned NC = 10;
    localparam int unsigned BC = 95;
    localparam int unsigned MI = 4;

    logic        clk = 1'b0;
    logic        rst, block_valid_i, issue_ready_i, result_valid_i, result_success_i, out_ready_i;
    logic [3:0]  result_prefix_i;
    logic        block_ready_o, newblock_o, issue_valid_o, out_valid_o, out_success_o;
    logic        busy_o, err_o;
    logic [31:0] issue_base_o, out_nonce_o;

    nonce_sweep_scheduler #(
        .NUM_CORES     (NC),
        .BROADCAST_CNT (BC),
        .MAX_INFLIGHT  (MI)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .block_valid_i    (block_valid_i),
        .block_ready_o    (block_ready_o),
        .newblock_o       (newblock_o),
        .issue_valid_o    (issue_valid_o),
        .issue_ready_i    (issue_ready_i),
        .issue_base_o     (issue_base_o),
        .result_valid_i   (result_valid_i),
        .result_success_i (result_success_i),
        .result_prefix_i  (result_prefix_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_success_o    (out_success_o),
        .out_nonce_o      (out_nonce_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         nb_accepts = 0;
    bit         hold_results = 1'b0;
    bit         hit_en = 1'b0;
    nonce_t     hit_base = '0;
    logic [3:0] hit_prefix = '0;
    nonce_t     q_base[$];
    int         q_due[$];
    nonce_t     iss_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: log this cycle's issue handshake, then present any due core result.
    task automatic tick();
        if (issue_valid_o && issue_ready_i) begin
            q_base.push_back(issue_base_o);
            q_due.push_back(cyc + 3);
            iss_log.push_back(issue_base_o);
            if (newblock_o) nb_accepts++;
        end
        @(posedge clk);
        #1;
        cyc++;
        result_valid_i   = 1'b0;
        result_success_i = 1'b0;
        result_prefix_i  = '0;
        if (!hold_results && q_base.size() > 0 && q_due[0] <= cyc) begin
            result_valid_i = 1'b1;
            if (hit_en && q_base[0] == hit_base) begin
                result_success_i = 1'b1;
                result_prefix_i  = hit_prefix;
            end
            void'(q_base.pop_front());
            void'(q_due.pop_front());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q_base.delete();
        q_due.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_block_ready"}, block_ready_o, 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_issue_valid"}, issue_valid_o, 0);
        check({tag, "_newblock"}, newblock_o, 0);
        check({tag, "_issue_base"}, issue_base_o, 0);
        check({tag, "_out_valid"}, out_valid_o, 0);
        check({tag, "_out_success"}, out_success_o, 0);
        check({tag, "_out_nonce"}, out_nonce_o, 0);
        check({tag, "_err"}, err_o, 0);
    endtask

    task automatic start_block();
        iss_log.delete();
        nb_accepts = 0;
        out_ready_i = 1'b0;
        check("start_ready", block_ready_o, 1);
        block_valid_i = 1'b1;
        tick();
        block_valid_i = 1'b0;
    endtask

    task automatic wait_report();
        int n = 0;
        while (!out_valid_o && n < 300) begin
            tick();
            n++;
        end
        check("report_reached", out_valid_o, 1);
    endtask

    task automatic finish_report(input string tag);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check({tag, "_ready_after_hs"}, block_ready_o, 1);
        check({tag, "_out_valid_after_hs"}, out_valid_o, 0);
    endtask

    // Full sweep with issue_ready high; checks the reported result and issue sequence.
    task automatic sweep(input string tag, input bit hen, input nonce_t hbase,
                         input logic [3:0] hpre, input logic exp_s, input nonce_t exp_n);
        hit_en        = hen;
        hit_base      = hbase;
        hit_prefix    = hpre;
        issue_ready_i = 1'b1;
        start_block();
        check({tag, "_newblock_first"}, newblock_o, 1);
        check({tag, "_first_base"}, issue_base_o, 0);
        wait_report();
        check({tag, "_success"}, out_success_o, exp_s);
        check({tag, "_nonce"}, out_nonce_o, exp_n);
        check({tag, "_newblock_once"}, nb_accepts, 1);
        check({tag, "_drained"}, q_base.size(), 0);
        check({tag, "_ready_in_report"}, block_ready_o, 0);
    endtask

    initial begin
        int  bad;
        bit  reached;
        rst = 1'b1;
        block_valid_i = 1'b0;
        issue_ready_i = 1'b0;
        result_valid_i = 1'b0;
        result_success_i = 1'b0;
        result_prefix_i = '0;
        out_ready_i = 1'b0;

        // Reset state
        do_reset();
        check_reset_outputs("rst");

        // No hit: ten issues with bases 0..90
        sweep("nohit", 1'b0, 0, 0, 1'b0, 0);
        check("nohit_issue_count", iss_log.size(), 10);
        bad = 0;
        foreach (iss_log[i]) if (iss_log[i] != nonce_t'(i * NC)) bad++;
        check("nohit_bases", bad, 0);
        check("nohit_err", err_o, 0);
        finish_report("nohit");

        // Hit in round 4, prefix 7; then hold REPORT under out_ready low
        sweep("hit47", 1'b1, 40, 7, 1'b1, 47);
`ifdef SCHED_EARLY_EXIT_EN
        check("hit47_early_exit", (iss_log.size() <= 8) && (iss_log[iss_log.size()-1] <= 70), 1);
`else
        check("hit47_all_issued", iss_log.size(), 10);
`endif
        block_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_out_valid", out_valid_o, 1);
            check("hold_nonce", out_nonce_o, 47);
            check("hold_success", out_success_o, 1);
            check("hold_block_ready", block_ready_o, 0);
        end
        block_valid_i = 1'b0;
        finish_report("hit47");
        check("hit47_no_reaccept", busy_o, 0);

        // Partial last round boundaries
        sweep("cand96", 1'b1, 90, 6, 1'b0, 0);
        finish_report("cand96");
        sweep("cand95", 1'b1, 90, 5, 1'b0, 0);
        finish_report("cand95");
        sweep("cand94", 1'b1, 90, 4, 1'b1, 94);
        finish_report("cand94");
        check("partial_err", err_o, 0);

        // Issue backpressure then inflight limit with results withheld
        hit_en = 1'b0;
        hold_results = 1'b1;
        issue_ready_i = 1'b0;
        start_block();
        for (int i = 0; i < 5; i++) begin
            check("bp_newblock", newblock_o, 1);
            check("bp_base", issue_base_o, 0);
            check("bp_valid", issue_valid_o, 1);
            tick();
        end
        issue_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("limit_accepts", iss_log.size(), MI);
        check("limit_valid_low", issue_valid_o, 0);
        check("limit_newblock_once", nb_accepts, 1);
        hold_results = 1'b0;
        wait_report();
        check("bp_issue_count", iss_log.size(), 10);
        check("bp_newblock_total", nb_accepts, 1);
        check("bp_success", out_success_o, 0);
        check("bp_err", err_o, 0);
        finish_report("bp");

        // Spurious result in IDLE sets sticky err
        result_valid_i = 1'b1;
        tick();
        check("spurious_err", err_o, 1);
        for (int i = 0; i < 3; i++) tick();
        check("spurious_sticky", err_o, 1);
        do_reset();
        check("err_cleared", err_o, 0);

        // Reset mid-ISSUE at base 30, late results flag err, then clean sweep
        issue_ready_i = 1'b1;
        start_block();
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (issue_valid_o && issue_base_o == 30) reached = 1'b1;
            else tick();
        end
        check("mid_base30_reached", reached, 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        check("late_pending", q_base.size() > 0, 1);
        for (int i = 0; i < 10; i++) tick();
        check("late_result_err", err_o, 1);
        do_reset();
        sweep("after_rst", 1'b0, 0, 0, 1'b0, 0);
        check("after_rst_first", iss_log[0], 0);
        check("after_rst_count", iss_log.size(), 10);
        check("after_rst_err", err_o, 0);
        finish_report("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
